// File: rtl/uart_tx_stream.sv
// uart_tx_stream: multi-word UART transmitter; ports clk, n_rst (sync active-low), tx_data/send_data in, serial_out/busy/done/byte_idx out; `UART_TX_PARITY_EN adds an even-parity bit
module uart_tx_stream #(
  parameter int NUM_BYTES    = 36,
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 8,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 1
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic [NUM_BYTES*DATA_BITS-1:0]     tx_data,
  input  logic                               send_data,
  output logic                               serial_out,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(NUM_BYTES+1)-1:0]     byte_idx
);
  localparam int IW = $clog2(NUM_BYTES + 1);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int PW = NUM_BYTES * DATA_BITS;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t               state_q;
  logic [TW-1:0]        tmr_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] sh_q;
  logic [PW-1:0]        pay_q;
  logic [IW-1:0]        idx_q;
  logic                 ser_q, busy_q, done_q;
  logic [DATA_BITS-1:0] cur, rev, ord;
  logic                 tick;
  // The word in flight always sits at the top of the payload register, which shifts up one word per frame.
  assign cur  = pay_q[PW-1 -: DATA_BITS];
  for (genvar i = 0; i < DATA_BITS; i++) begin : g_rev
    assign rev[i] = cur[DATA_BITS-1-i];
  end
  // ord is the word rearranged so that bit 0 goes out first.
  assign ord  = (MSB_FIRST != 0) ? rev : cur;
  assign tick = tmr_q == TW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      pay_q   <= '0;
      idx_q   <= '0;
      ser_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      tmr_q  <= (state_q == IDLE || tick) ? '0 : tmr_q + TW'(1);
      case (state_q)
        IDLE: if (send_data) begin
          pay_q   <= tx_data;
          bit_q   <= '0;
          idx_q   <= '0;
          busy_q  <= 1'b1;
          ser_q   <= 1'b0;
          state_q <= START;
        end
        START: if (tick) begin
          state_q <= DATA;
          bit_q   <= '0;
          ser_q   <= ord[0];
          sh_q    <= ord >> 1;
        end
        DATA: if (tick) begin
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
            state_q <= PARITY;
            ser_q   <= ^cur;
`else
            state_q <= STOP;
            ser_q   <= 1'b1;
`endif
          end else begin
            bit_q <= bit_q + BW'(1);
            ser_q <= sh_q[0];
            sh_q  <= sh_q >> 1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (tick) begin
          state_q <= STOP;
          ser_q   <= 1'b1;
        end
`endif
        STOP: if (tick) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_q <= '0;
            idx_q <= idx_q + IW'(1);
            pay_q <= pay_q << DATA_BITS;
            if (idx_q == IW'(NUM_BYTES - 1)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              ser_q   <= 1'b1;
            end else begin
              state_q <= START;
              ser_q   <= 1'b0;
            end
          end else begin
            bit_q <= bit_q + BW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign serial_out = ser_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign byte_idx   = idx_q;
endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: randomized checks of three uart_tx_stream configurations against a frame-arithmetic model
module tb_uart_tx_stream;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int CF_NB [3]  = '{36, 2, 1};
  localparam int CF_DB [3]  = '{8, 7, 8};
  localparam int CF_CPB [3] = '{8, 4, 4};
  localparam int CF_SB [3]  = '{1, 2, 1};
  localparam int CF_MSB [3] = '{1, 0, 1};
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic [287:0] tx0 = '0;
  logic [13:0]  tx1 = '0;
  logic [7:0]   tx2 = '0;
  logic s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
  logic so0, so1, so2, b0, b1, b2, d0, d1, d2;
  logic [5:0] i0;
  logic [1:0] i1;
  logic [0:0] i2;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  uart_tx_stream u0 (
    .clk(clk), .n_rst(n_rst), .tx_data(tx0), .send_data(s0),
    .serial_out(so0), .busy(b0), .done(d0), .byte_idx(i0)
  );
  uart_tx_stream #(.NUM_BYTES(2), .DATA_BITS(7), .CLKS_PER_BIT(4), .STOP_BITS(2), .MSB_FIRST(0)) u1 (
    .clk(clk), .n_rst(n_rst), .tx_data(tx1), .send_data(s1),
    .serial_out(so1), .busy(b1), .done(d1), .byte_idx(i1)
  );
  uart_tx_stream #(.NUM_BYTES(1), .DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .MSB_FIRST(1)) u2 (
    .clk(clk), .n_rst(n_rst), .tx_data(tx2), .send_data(s2),
    .serial_out(so2), .busy(b2), .done(d2), .byte_idx(i2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic ser_of(input int s);
    return s == 0 ? so0 : s == 1 ? so1 : so2;
  endfunction
  function automatic logic busy_of(input int s);
    return s == 0 ? b0 : s == 1 ? b1 : b2;
  endfunction
  function automatic logic done_of(input int s);
    return s == 0 ? d0 : s == 1 ? d1 : d2;
  endfunction
  function automatic logic [31:0] idx_of(input int s);
    return s == 0 ? 32'(i0) : s == 1 ? 32'(i1) : 32'(i2);
  endfunction
  task automatic set_send(input int s, input logic v);
    if (s == 0) s0 = v;
    else if (s == 1) s1 = v;
    else s2 = v;
  endtask
  task automatic set_tx(input int s, input logic [287:0] d);
    if (s == 0) tx0 = d;
    else if (s == 1) tx1 = d[13:0];
    else tx2 = d[7:0];
  endtask
  function automatic logic [287:0] rnd();
    logic [287:0] r;
    for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  // Expected line level j cycles after the accept: frame, bit slot and word follow from division alone.
  function automatic logic exp_bit(input int s, input logic [287:0] d, input int j);
    int fb, fr, b, k;
    logic [287:0] w, t;
    fb = 1 + CF_DB[s] + P + CF_SB[s];
    fr = j / (fb * CF_CPB[s]);
    b  = (j % (fb * CF_CPB[s])) / CF_CPB[s];
    w  = (d >> ((CF_NB[s] - 1 - fr) * CF_DB[s])) & ((288'd1 << CF_DB[s]) - 288'd1);
    if (b == 0) return 1'b0;
    if (b <= CF_DB[s]) begin
      k = CF_MSB[s] != 0 ? CF_DB[s] - b : b - 1;
      t = w >> k;
      return t[0];
    end
    if (P == 1 && b == CF_DB[s] + 1) return ^w;
    return 1'b1;
  endfunction
  // Starts at #1 after an edge and ends there; b2b asserts send_data in the current (done) cycle.
  task automatic run(input int s, input logic [287:0] d, input bit b2b, input int abort_at);
    int fcyc, len, mid, errs, nd;
    fcyc = (1 + CF_DB[s] + P + CF_SB[s]) * CF_CPB[s];
    len  = CF_NB[s] * fcyc;
    mid  = $urandom_range(len - 2, 1);
    errs = 0;
    if (!b2b) begin
      repeat (3) @(posedge clk);
      #1;
      chk("pre_idle_ser", 32'(ser_of(s)), 32'd1);
      chk("pre_idle_busy", 32'(busy_of(s)), 32'd0);
    end
    set_send(s, 1'b1);
    set_tx(s, d);
    @(posedge clk);
    #1;
    set_send(s, 1'b0);
    set_tx(s, rnd());
    for (int j = 0; j < len; j++) begin
      if (j == abort_at) begin
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        chk("abort_ser", 32'(ser_of(s)), 32'd1);
        chk("abort_busy", 32'(busy_of(s)), 32'd0);
        chk("abort_idx", idx_of(s), 32'd0);
        nd = 0;
        repeat (len - j + 20) begin
          if (done_of(s) !== 1'b0 || ser_of(s) !== 1'b1) nd++;
          @(posedge clk);
          #1;
        end
        chk("abort_quiet", 32'(nd), 32'd0);
        chk("pre_abort_wave", 32'(errs), 32'd0);
        return;
      end
      if (ser_of(s) !== exp_bit(s, d, j)) errs++;
      if (busy_of(s) !== 1'b1 || done_of(s) !== 1'b0 || idx_of(s) !== 32'(j / fcyc)) errs++;
      set_send(s, j == mid);
      if (j == mid) set_tx(s, rnd());
      @(posedge clk);
      #1;
    end
    set_send(s, 1'b0);
    chk($sformatf("wave%0d", s), 32'(errs), 32'd0);
    chk($sformatf("done%0d", s), 32'(done_of(s)), 32'd1);
    chk($sformatf("end_busy%0d", s), 32'(busy_of(s)), 32'd0);
    chk($sformatf("end_idx%0d", s), idx_of(s), 32'(CF_NB[s]));
    chk($sformatf("end_ser%0d", s), 32'(ser_of(s)), 32'd1);
  endtask
  initial begin
    int errs, f0;
    logic [287:0] d;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ser", 32'(so0), 32'd1);
    chk("rst_busy", 32'(b0), 32'd0);
    chk("rst_done", 32'(d0), 32'd0);
    chk("rst_idx", 32'(i0), 32'd0);
    n_rst = 1'b1;
    errs = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++)
        if (ser_of(s) !== 1'b1 || busy_of(s) !== 1'b0 || done_of(s) !== 1'b0 || idx_of(s) !== 32'd0) errs++;
    end
    chk("idle20", 32'(errs), 32'd0);
    d = '0;
    d[7:0] = 8'hA5;
    run(0, d, 1'b0, -1);
    run(0, rnd(), 1'b1, -1);
    f0 = (1 + 8 + P + 1) * 8;
    run(0, rnd(), 1'b0, 15 * f0 + f0 / 2);
    run(0, rnd(), 1'b0, -1);
    d = '0;
    d[13:0] = 14'h1555;
    run(1, d, 1'b0, -1);
    for (int n = 0; n < 6; n++) run(1, rnd(), 1'($urandom_range(1, 0)), -1);
    d = '0;
    d[7:0] = 8'h07;
    run(2, d, 1'b0, -1);
    for (int n = 0; n < 6; n++) run(2, rnd(), 1'($urandom_range(1, 0)), -1);
    errs = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (so2 !== 1'b1 || b2 !== 1'b0 || d2 !== 1'b0) errs++;
    end
    chk("final_idle", 32'(errs), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
